// File: rtl/memory_access_unit.sv
// Load/store bus master: accepts one core request, checks alignment, runs one single-beat bus cycle.
// Latency: Done 1 cycle after the request edge on an alignment fault, 3 cycles with a zero-wait slave, +1 per Stall cycle.
// Backpressure: Stall holds Strobe in place; Request is ignored while Busy (until the cycle after Done).
module memory_access_unit #(
  parameter int TIMEOUT_CYCLES   = 16,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_request,
  input  logic        i_write,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_address,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_load_data,
  output logic        o_cycle,
  output logic        o_strobe,
  output logic        o_read_write,
  output logic [1:0]  o_width,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_data_out,
  input  logic [31:0] i_bus_data_in,
  input  logic        i_acknowledge,
  input  logic        i_stall
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_write;
  logic          r_signed;
  logic [1:0]    r_size;

  logic          w_illegal;
  logic [31:0]   w_store_masked;
  logic [31:0]   w_load_ext;
  logic          w_timeout;

  // Alignment / legality of the request currently presented at the core port
  always_comb begin
    w_illegal = 1'b0;
    if (!ALLOW_MISALIGNED) begin
      case (i_size)
        2'd1:    w_illegal = i_address[0];
        2'd2:    w_illegal = (i_address[1:0] != 2'b00);
        2'd3:    w_illegal = 1'b1;
        default: w_illegal = 1'b0;
      endcase
    end
  end

  // Store data trimmed to the access width so the slave never sees stale upper bytes
  always_comb begin
    w_store_masked = i_store_data;
    case (i_size)
      2'd0:    w_store_masked = {24'h0, i_store_data[7:0]};
      2'd1:    w_store_masked = {16'h0, i_store_data[15:0]};
      default: w_store_masked = i_store_data;
    endcase
  end

  // Sign/zero extension of the right-aligned slave data, using the latched size and Signed
  always_comb begin
    w_load_ext = i_bus_data_in;
    case (r_size)
      2'd0:    w_load_ext = {{24{r_signed & i_bus_data_in[7]}}, i_bus_data_in[7:0]};
      2'd1:    w_load_ext = {{16{r_signed & i_bus_data_in[15]}}, i_bus_data_in[15:0]};
      default: w_load_ext = i_bus_data_in;
    endcase
  end

  // The current WAIT cycle is the last one allowed before faulting
  assign w_timeout = (r_count == CW'(TIMEOUT_CYCLES - 1));

  // Request sequencing with all outputs registered; Done is a one-cycle pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_write        <= 1'b0;
      r_signed       <= 1'b0;
      r_size         <= 2'd0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_fault        <= 1'b0;
      o_load_data    <= 32'h0;
      o_cycle        <= 1'b0;
      o_strobe       <= 1'b0;
      o_read_write   <= 1'b0;
      o_width        <= 2'd0;
      o_bus_address  <= 32'h0;
      o_bus_data_out <= 32'h0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_request) begin
            r_write  <= i_write;
            r_size   <= i_size;
            r_signed <= i_signed;
            o_busy   <= 1'b1;
            if (w_illegal) begin
              // Illegal access completes immediately without touching the bus
              r_state     <= S_DONE;
              o_done      <= 1'b1;
              o_fault     <= 1'b1;
              o_load_data <= 32'h0;
            end else begin
              r_state        <= S_STROBE;
              o_cycle        <= 1'b1;
              o_strobe       <= 1'b1;
              o_read_write   <= i_write;
              o_width        <= i_size;
              o_bus_address  <= i_address;
              o_bus_data_out <= w_store_masked;
            end
          end
        end

        S_STROBE: begin
          if (i_acknowledge) begin
            // Slave completed while the strobe was still up
            r_state      <= S_DONE;
            o_done       <= 1'b1;
            o_fault      <= 1'b0;
            o_load_data  <= r_write ? 32'h0 : w_load_ext;
            o_cycle      <= 1'b0;
            o_strobe     <= 1'b0;
            o_read_write <= 1'b0;
          end else if (!i_stall) begin
            r_state  <= S_WAIT;
            o_strobe <= 1'b0;
            r_count  <= '0;
          end
        end

        S_WAIT: begin
          if (i_acknowledge || w_timeout) begin
            r_state      <= S_DONE;
            o_done       <= 1'b1;
            o_fault      <= !i_acknowledge;
            o_load_data  <= (i_acknowledge && !r_write) ? w_load_ext : 32'h0;
            o_cycle      <= 1'b0;
            o_strobe     <= 1'b0;
            o_read_write <= 1'b0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end

        default: begin
          // DONE: pulse already issued, return to IDLE and drop the result
          r_state     <= S_IDLE;
          o_busy      <= 1'b0;
          o_fault     <= 1'b0;
          o_load_data <= 32'h0;
        end
      endcase
    end
  end

endmodule
